// File: rtl/ucode_rom_arbiter_if.sv
// Bus bundle between the control-unit fetch paths, the micro-code ROM and the ROM arbiter.
// The arbiter uses the slave modport; the requester/ROM side uses the master modport.
interface ucode_rom_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              flush_pipeline;
    logic              norm_req;
    logic [ADDR_W-1:0] norm_addr;
    logic              norm_gnt;
    logic              norm_rvalid;
    logic [DATA_W-1:0] norm_rdata;
    logic              spec_req;
    logic [ADDR_W-1:0] spec_addr;
    logic              spec_gnt;
    logic              spec_rvalid;
    logic [DATA_W-1:0] spec_rdata;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              spec_starved;

    modport slave (
        input  flush_pipeline, norm_req, norm_addr, spec_req, spec_addr, rom_data,
        output norm_gnt, norm_rvalid, norm_rdata, spec_gnt, spec_rvalid, spec_rdata,
        output rom_en, rom_addr, spec_starved
    );

    modport master (
        output flush_pipeline, norm_req, norm_addr, spec_req, spec_addr, rom_data,
        input  norm_gnt, norm_rvalid, norm_rdata, spec_gnt, spec_rvalid, spec_rdata,
        input  rom_en, rom_addr, spec_starved
    );
endinterface

// File: rtl/ucode_rom_arbiter.sv
// Single-port micro-code ROM arbiter for the normal and speculative fetch paths, with starvation
// priority handover and flush cancel. Define UCODE_ARB_MERGE_EN to merge equal-address requests.
module ucode_rom_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input logic                  clk,
    input logic                  rst,
    ucode_rom_arbiter_if.slave   bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_reg;
    logic [2:0] starve_cnt_next;
    logic       norm_own_reg;
    logic       spec_own_reg;

    logic       norm_gnt;
    logic       spec_gnt;
    logic       starved;
    logic       active;
    logic       same_addr;

    always_comb begin
        starved   = (starve_cnt_reg == LIMIT);
        // Grants are suppressed while reset is asserted or a flush is in progress.
        active    = rst && !bus.flush_pipeline;
`ifdef UCODE_ARB_MERGE_EN
        same_addr = (bus.norm_addr == bus.spec_addr);
`else
        same_addr = 1'b0;
`endif
        norm_gnt  = 1'b0;
        spec_gnt  = 1'b0;
        if (active) begin
            if (bus.norm_req && bus.spec_req) begin
                if (same_addr) begin
                    norm_gnt = 1'b1;
                    spec_gnt = 1'b1;
                end else if (starved) begin
                    spec_gnt = 1'b1;
                end else begin
                    norm_gnt = 1'b1;
                end
            end else begin
                norm_gnt = bus.norm_req;
                spec_gnt = bus.spec_req;
            end
        end
    end

    // Saturating count of consecutive denied speculative cycles; flush and grant both clear it.
    always_comb begin
        starve_cnt_next = 3'd0;
        if (bus.spec_req && !spec_gnt && !bus.flush_pipeline) begin
            starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_reg <= 3'd0;
            norm_own_reg   <= 1'b0;
            spec_own_reg   <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            norm_own_reg   <= norm_gnt;
            spec_own_reg   <= spec_gnt;
        end
    end

    assign bus.norm_gnt     = norm_gnt;
    assign bus.spec_gnt     = spec_gnt;
    assign bus.rom_en       = norm_gnt | spec_gnt;
    assign bus.rom_addr     = norm_gnt ? bus.norm_addr :
                              spec_gnt ? bus.spec_addr : {ADDR_W{1'b1}};
    assign bus.spec_starved = starved;
    assign bus.norm_rvalid  = norm_own_reg;
    assign bus.spec_rvalid  = spec_own_reg;
    assign bus.norm_rdata   = norm_own_reg ? bus.rom_data : {DATA_W{1'b0}};
    assign bus.spec_rdata   = spec_own_reg ? bus.rom_data : {DATA_W{1'b0}};
endmodule

// File: tb/tb_ucode_rom_arbiter.sv
// Directed bench for ucode_rom_arbiter: reset, single requesters, contention/starvation,
// merge (either build of UCODE_ARB_MERGE_EN), flush, and reset in the middle of starvation.
module tb_ucode_rom_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ucode_rom_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    ucode_rom_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic nr, input logic [7:0] na, input logic sr, input logic [7:0] sa);
        bus.norm_req  = nr;
        bus.norm_addr = na;
        bus.spec_req  = sr;
        bus.spec_addr = sa;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        bus.flush_pipeline = 1'b0;
        bus.rom_data = 32'h0;
        set_req(1'b1, 8'h20, 1'b1, 8'h40);

        // Reset held two cycles with both paths requesting
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_norm_gnt", bus.norm_gnt, 0);
            chk("rst_spec_gnt", bus.spec_gnt, 0);
            chk("rst_rom_en", bus.rom_en, 0);
            chk("rst_rom_addr", bus.rom_addr, 32'hFF);
            chk("rst_norm_rvalid", bus.norm_rvalid, 0);
            chk("rst_spec_rvalid", bus.spec_rvalid, 0);
            chk("rst_norm_rdata", bus.norm_rdata, 0);
            chk("rst_spec_rdata", bus.spec_rdata, 0);
            chk("rst_starved", bus.spec_starved, 0);
            next_cycle();
        end
        rst = 1'b1;

        // Contention: N..N+2 normal wins, N+3 speculative wins, N+4 normal again
        @(negedge clk);
        chk("cont_n_norm_gnt", bus.norm_gnt, 1);
        chk("cont_n_spec_gnt", bus.spec_gnt, 0);
        chk("cont_n_rom_addr", bus.rom_addr, 32'h20);
        chk("cont_n_starved", bus.spec_starved, 0);
        next_cycle();
        bus.rom_data = 32'hA1A1_0001;
        @(negedge clk);
        chk("cont_n1_norm_gnt", bus.norm_gnt, 1);
        chk("cont_n1_norm_rvalid", bus.norm_rvalid, 1);
        chk("cont_n1_norm_rdata", bus.norm_rdata, 32'hA1A1_0001);
        chk("cont_n1_spec_rvalid", bus.spec_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("cont_n2_norm_gnt", bus.norm_gnt, 1);
        chk("cont_n2_starved", bus.spec_starved, 0);
        next_cycle();
        @(negedge clk);
        chk("cont_n3_starved", bus.spec_starved, 1);
        chk("cont_n3_spec_gnt", bus.spec_gnt, 1);
        chk("cont_n3_norm_gnt", bus.norm_gnt, 0);
        chk("cont_n3_rom_addr", bus.rom_addr, 32'h40);
        chk("cont_n3_rom_en", bus.rom_en, 1);
        next_cycle();
        bus.rom_data = 32'hB2B2_0002;
        @(negedge clk);
        chk("cont_n4_norm_gnt", bus.norm_gnt, 1);
        chk("cont_n4_spec_gnt", bus.spec_gnt, 0);
        chk("cont_n4_starved", bus.spec_starved, 0);
        chk("cont_n4_spec_rvalid", bus.spec_rvalid, 1);
        chk("cont_n4_spec_rdata", bus.spec_rdata, 32'hB2B2_0002);
        chk("cont_n4_norm_rvalid", bus.norm_rvalid, 0);
        chk("cont_n4_norm_rdata", bus.norm_rdata, 0);

        // Idle
        next_cycle();
        set_req(1'b0, 8'h20, 1'b0, 8'h40);
        bus.rom_data = 32'h0;
        @(negedge clk);
        chk("idle_rom_en", bus.rom_en, 0);
        chk("idle_rom_addr", bus.rom_addr, 32'hFF);

        // Normal only, data returned next cycle
        next_cycle();
        set_req(1'b1, 8'h10, 1'b0, 8'h00);
        @(negedge clk);
        chk("norm_gnt", bus.norm_gnt, 1);
        chk("norm_spec_gnt", bus.spec_gnt, 0);
        chk("norm_rom_addr", bus.rom_addr, 32'h10);
        chk("norm_rom_en", bus.rom_en, 1);
        next_cycle();
        set_req(1'b0, 8'h10, 1'b0, 8'h00);
        bus.rom_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("norm_rvalid", bus.norm_rvalid, 1);
        chk("norm_rdata", bus.norm_rdata, 32'hDEADBEEF);
        chk("norm_spec_rvalid", bus.spec_rvalid, 0);
        chk("norm_spec_rdata", bus.spec_rdata, 0);
        chk("norm_ret_rom_en", bus.rom_en, 0);

        // Speculative only
        next_cycle();
        set_req(1'b0, 8'h00, 1'b1, 8'h55);
        @(negedge clk);
        chk("spec_gnt", bus.spec_gnt, 1);
        chk("spec_norm_gnt", bus.norm_gnt, 0);
        chk("spec_rom_addr", bus.rom_addr, 32'h55);
        next_cycle();
        set_req(1'b0, 8'h00, 1'b0, 8'h00);
        bus.rom_data = 32'h5A5A_A5A5;
        @(negedge clk);
        chk("spec_rvalid", bus.spec_rvalid, 1);
        chk("spec_rdata", bus.spec_rdata, 32'h5A5A_A5A5);
        chk("spec_norm_rvalid", bus.norm_rvalid, 0);

        // Same-address requests
        next_cycle();
        set_req(1'b1, 8'h33, 1'b1, 8'h33);
        bus.rom_data = 32'h0;
        @(negedge clk);
        chk("merge_rom_addr", bus.rom_addr, 32'h33);
        chk("merge_rom_en", bus.rom_en, 1);
        chk("merge_norm_gnt", bus.norm_gnt, 1);
`ifdef UCODE_ARB_MERGE_EN
        chk("merge_spec_gnt", bus.spec_gnt, 1);
        next_cycle();
        set_req(1'b0, 8'h33, 1'b0, 8'h33);
        bus.rom_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("merge_norm_rvalid", bus.norm_rvalid, 1);
        chk("merge_spec_rvalid", bus.spec_rvalid, 1);
        chk("merge_norm_rdata", bus.norm_rdata, 32'hCAFE_F00D);
        chk("merge_spec_rdata", bus.spec_rdata, 32'hCAFE_F00D);
        chk("merge_ret_rom_en", bus.rom_en, 0);
`else
        chk("nomerge_spec_gnt", bus.spec_gnt, 0);
        next_cycle();
        set_req(1'b0, 8'h33, 1'b1, 8'h33);
        bus.rom_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("nomerge_n1_spec_gnt", bus.spec_gnt, 1);
        chk("nomerge_n1_rom_addr", bus.rom_addr, 32'h33);
        chk("nomerge_n1_norm_rvalid", bus.norm_rvalid, 1);
        chk("nomerge_n1_spec_rvalid", bus.spec_rvalid, 0);
        chk("nomerge_n1_norm_rdata", bus.norm_rdata, 32'hCAFE_F00D);
        next_cycle();
        set_req(1'b0, 8'h33, 1'b0, 8'h33);
        bus.rom_data = 32'h1357_9BDF;
        @(negedge clk);
        chk("nomerge_n2_spec_rvalid", bus.spec_rvalid, 1);
        chk("nomerge_n2_spec_rdata", bus.spec_rdata, 32'h1357_9BDF);
        chk("nomerge_n2_norm_rvalid", bus.norm_rvalid, 0);
`endif

        // Flush: spec denied twice, flush cycle, then counter restarts from 0
        next_cycle();
        set_req(1'b1, 8'h70, 1'b1, 8'h90);
        bus.rom_data = 32'h0;
        @(negedge clk);
        chk("fl_a_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("fl_b_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        bus.flush_pipeline = 1'b1;
        bus.rom_data = 32'h1234_5678;
        @(negedge clk);
        chk("fl_c_norm_gnt", bus.norm_gnt, 0);
        chk("fl_c_spec_gnt", bus.spec_gnt, 0);
        chk("fl_c_rom_en", bus.rom_en, 0);
        chk("fl_c_rom_addr", bus.rom_addr, 32'hFF);
        chk("fl_c_norm_rvalid", bus.norm_rvalid, 1);
        chk("fl_c_norm_rdata", bus.norm_rdata, 32'h1234_5678);
        next_cycle();
        bus.flush_pipeline = 1'b0;
        @(negedge clk);
        chk("fl_d_norm_rvalid", bus.norm_rvalid, 0);
        chk("fl_d_spec_rvalid", bus.spec_rvalid, 0);
        chk("fl_d_norm_rdata", bus.norm_rdata, 0);
        chk("fl_d_starved", bus.spec_starved, 0);
        chk("fl_d_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("fl_e_starved", bus.spec_starved, 0);
        chk("fl_e_spec_gnt", bus.spec_gnt, 0);
        next_cycle();
        @(negedge clk);
        chk("fl_f_starved", bus.spec_starved, 0);
        next_cycle();
        @(negedge clk);
        chk("fl_g_starved", bus.spec_starved, 1);
        chk("fl_g_spec_gnt", bus.spec_gnt, 1);

        // Reset mid-operation: spec denied twice, one reset cycle, counter restarts
        next_cycle();
        set_req(1'b1, 8'h20, 1'b1, 8'h40);
        @(negedge clk);
        chk("mr_h_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("mr_i_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_j_norm_gnt", bus.norm_gnt, 0);
        chk("mr_j_spec_gnt", bus.spec_gnt, 0);
        chk("mr_j_rom_en", bus.rom_en, 0);
        chk("mr_j_rom_addr", bus.rom_addr, 32'hFF);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_k_norm_rvalid", bus.norm_rvalid, 0);
        chk("mr_k_spec_rvalid", bus.spec_rvalid, 0);
        chk("mr_k_starved", bus.spec_starved, 0);
        chk("mr_k_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("mr_l_starved", bus.spec_starved, 0);
        next_cycle();
        @(negedge clk);
        chk("mr_m_starved", bus.spec_starved, 0);
        chk("mr_m_norm_gnt", bus.norm_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("mr_n_starved", bus.spec_starved, 1);
        chk("mr_n_spec_gnt", bus.spec_gnt, 1);
        chk("mr_n_rom_addr", bus.rom_addr, 32'h40);

        next_cycle();
        set_req(1'b0, 8'h00, 1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
